// File: rtl/depacketizer_pkg.sv
// Shared types and helpers for the gyro HSI depacketizer.
package depacketizer_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'b00,
    DRAIN   = 2'b01,
    DISCARD = 2'b10
  } state_t;

  // Index width for a packet buffer of the given depth, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/pkt_word_buf.sv
// One-packet word store: synchronous write, combinational read, no reset on storage.
module pkt_word_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/depacketizer.sv
// Receives fixed-length stream packets, checks framing, buffers one packet
// and replays it as a contiguous word burst with saturating status counters.
module depacketizer #(
  parameter int PKT_WORDS = 8,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              last_out,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);
  import depacketizer_pkg::*;

  localparam int IDX_W = clog2(PKT_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  wr_next;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rd_next;
  logic              accept;
  logic              buf_we;
  logic              err_event;
  logic              pkt_done;
  logic [DATA_W-1:0] rd_data;

  // Held low while in reset so nothing upstream sees a ready before release.
  assign s_tready = reset_n && (state != DRAIN);
  assign accept   = s_tvalid && s_tready;

  pkt_word_buf #(
    .DEPTH  (PKT_WORDS),
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W)
  ) u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (wr_idx),
    .wdata (s_tdata),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      state  <= next_state;
      wr_idx <= wr_next;
      rd_idx <= rd_next;
    end
  end

  always_comb begin
    next_state = state;
    wr_next    = wr_idx;
    rd_next    = rd_idx;
    buf_we     = 1'b0;
    err_event  = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          buf_we = 1'b1;
          if (s_tlast) begin
            wr_next = '0;
            if (wr_idx == LAST_IDX) next_state = DRAIN;
            else                    err_event  = 1'b1;
          end else if (wr_idx == LAST_IDX) begin
            // Over-length packet: swallow the remainder up to its TLAST.
            wr_next    = '0;
            next_state = DISCARD;
            err_event  = 1'b1;
          end else begin
            wr_next = wr_idx + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && s_tlast) next_state = FILL;
      end
      DRAIN: begin
        if (rd_idx == LAST_IDX) begin
          rd_next    = '0;
          next_state = FILL;
          pkt_done   = 1'b1;
        end else begin
          rd_next = rd_idx + 1'b1;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // Output stage and counters; data_out only updates while draining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      err_pulse <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      valid_out <= (state == DRAIN);
      last_out  <= (state == DRAIN) && (rd_idx == LAST_IDX);
      err_pulse <= err_event;
      if (state == DRAIN) data_out <= rd_data;
      if (pkt_done && (pkt_count != {CNT_W{1'b1}})) pkt_count <= pkt_count + 1'b1;
      if (err_event && (err_count != {CNT_W{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_depacketizer.sv
// Randomised self-checking bench for depacketizer against a packet-level reference model.
module tb_depacketizer;

  localparam int PKT_WORDS = 8;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 16;
  localparam int SAT_W     = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;
  logic              err_pulse;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  err_count;

  logic              sat_tready;
  logic [DATA_W-1:0] sat_data_out;
  logic              sat_valid_out;
  logic              sat_last_out;
  logic              sat_err_pulse;
  logic [SAT_W-1:0]  sat_pkt_count;
  logic [SAT_W-1:0]  sat_err_count;

  int total = 0;
  int bad = 0;
  logic [DATA_W:0] obs_q[$];
  logic [DATA_W:0] exp_q[$];
  int exp_pkt = 0;
  int exp_err = 0;
  int err_seen = 0;
  int sat_err_seen = 0;
  int sat_out_cycles = 0;

  depacketizer #(.PKT_WORDS(PKT_WORDS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .data_out(data_out),
    .valid_out(valid_out), .last_out(last_out), .err_pulse(err_pulse),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  // Narrow-counter copy so saturation is reachable in a handful of packets.
  depacketizer #(.PKT_WORDS(PKT_WORDS), .DATA_W(DATA_W), .CNT_W(SAT_W)) dut_sat (
    .clock(clock), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(sat_tready), .data_out(sat_data_out),
    .valid_out(sat_valid_out), .last_out(sat_last_out), .err_pulse(sat_err_pulse),
    .pkt_count(sat_pkt_count), .err_count(sat_err_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      if (valid_out) obs_q.push_back({last_out, data_out});
      if (err_pulse) err_seen++;
      if (sat_err_pulse) sat_err_seen++;
      if (sat_valid_out || sat_last_out) sat_out_cycles++;
    end
  end

  // Reference model: a packet is good only if TLAST lands exactly on word PKT_WORDS.
  task automatic model_packet(input int len, input logic [DATA_W-1:0] base);
    if (len == PKT_WORDS) begin
      for (int i = 0; i < PKT_WORDS; i++) exp_q.push_back({i == PKT_WORDS - 1, base + DATA_W'(i)});
      exp_pkt++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!s_tready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: s_tready=%0b after %0d cycles, want 1", s_tready, guard);
    end
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
    @(posedge clock);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_packet(input int len, input logic [DATA_W-1:0] base, input int max_gap);
    model_packet(len, base);
    for (int i = 0; i < len; i++) begin
      drive_beat(base + DATA_W'(i), i == len - 1);
      if (max_gap > 0 && i != len - 1) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic settle();
    repeat (PKT_WORDS + 4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    err_seen = 0;
    sat_err_seen = 0;
    sat_out_cycles = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    total++;
    if ({valid_out, last_out, err_pulse} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 000", {valid_out, last_out, err_pulse});
    end
    total++;
    if (data_out !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h want 0", data_out);
    end
    total++;
    if (pkt_count !== '0 || err_count !== '0) begin
      bad++;
      $display("[TB] FAIL reset_counts: got pkt=%0d err=%0d want 0/0", pkt_count, err_count);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b want 1", s_tready);
    end
  endtask

  // Samples the ten cycles after the TLAST edge and checks valid/last/ready shape.
  task automatic check_drain_timing(input string name);
    logic [9:0] v_mask, l_mask, r_low;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      v_mask[k] = valid_out;
      l_mask[k] = last_out;
      r_low[k]  = !s_tready;
    end
    total++;
    if (v_mask !== 10'b01_1111_1110) begin
      bad++;
      $display("[TB] FAIL %s_valid: got %b want %b", name, v_mask, 10'b01_1111_1110);
    end
    total++;
    if (l_mask !== 10'b01_0000_0000) begin
      bad++;
      $display("[TB] FAIL %s_last: got %b want %b", name, l_mask, 10'b01_0000_0000);
    end
    total++;
    if (r_low !== 10'b00_1111_1111) begin
      bad++;
      $display("[TB] FAIL %s_ready_low: got %b want %b", name, r_low, 10'b00_1111_1111);
    end
  endtask

  task automatic check_stream(input string name);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL %s_len: got %0d words want %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL %s_word%0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
          break;
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
    total++;
    if (pkt_count !== CNT_W'(exp_pkt) || err_count !== CNT_W'(exp_err)) begin
      bad++;
      $display("[TB] FAIL %s_counts: got pkt=%0d err=%0d want %0d/%0d", name, pkt_count, err_count, exp_pkt, exp_err);
    end
  endtask

  task automatic test_good_packet();
    model_packet(PKT_WORDS, 32'h1000_0000);
    for (int i = 0; i < PKT_WORDS; i++) drive_beat(32'h1000_0000 + DATA_W'(i), i == PKT_WORDS - 1);
    check_drain_timing("good");
    check_stream("good");
  endtask

  task automatic test_short_packet();
    int e0;
    e0 = err_seen;
    send_packet(5, 32'h0000_0050, 0);
    settle();
    total++;
    if (err_seen - e0 != 1) begin
      bad++;
      $display("[TB] FAIL short_pulses: got %0d want 1", err_seen - e0);
    end
    check_stream("short_drop");
    send_packet(PKT_WORDS, 32'h0000_00A0, 0);
    settle();
    check_stream("short_next");
  endtask

  task automatic test_long_packet();
    int e0;
    e0 = err_seen;
    model_packet(11, 32'h0000_0B00);
    for (int i = 0; i < 11; i++) begin
      drive_beat(32'h0000_0B00 + DATA_W'(i), i == 10);
      if (i == PKT_WORDS - 1) begin
        total++;
        if (err_pulse !== 1'b1) begin
          bad++;
          $display("[TB] FAIL long_pulse_at8: got %b want 1", err_pulse);
        end
      end
    end
    settle();
    total++;
    if (err_seen - e0 != 1) begin
      bad++;
      $display("[TB] FAIL long_pulses: got %0d want 1", err_seen - e0);
    end
    check_stream("long_drop");
    send_packet(PKT_WORDS, 32'h0000_0C00, 0);
    settle();
    check_stream("long_next");
  endtask

  task automatic test_gapped();
    model_packet(PKT_WORDS, 32'h1000_0000);
    for (int i = 0; i < PKT_WORDS; i++) begin
      drive_beat(32'h1000_0000 + DATA_W'(i), i == PKT_WORDS - 1);
      if (i == 1) idle(3);
      if (i == 5) idle(1);
    end
    check_drain_timing("gapped");
    check_stream("gapped");
  endtask

  task automatic test_reset_mid_drain();
    int guard;
    send_packet(PKT_WORDS, 32'h2000_0000, 0);
    guard = 0;
    while (obs_q.size() < 3 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    total++;
    if (obs_q.size() < 3) begin
      bad++;
      $display("[TB] FAIL middrain_wait: got %0d words want 3", obs_q.size());
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({valid_out, last_out, err_pulse} !== 3'b000 || data_out !== '0) begin
      bad++;
      $display("[TB] FAIL middrain_outputs: got v/l/e=%b data=%h want 000/0", {valid_out, last_out, err_pulse}, data_out);
    end
    total++;
    if (pkt_count !== '0 || err_count !== '0) begin
      bad++;
      $display("[TB] FAIL middrain_counts: got pkt=%0d err=%0d want 0/0", pkt_count, err_count);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    obs_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    err_seen = 0;
    reset_n = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL middrain_ready: got %b want 1", s_tready);
    end
    send_packet(PKT_WORDS, 32'h3000_0000, 0);
    settle();
    check_stream("middrain_fresh");
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 25; p++) begin
      len = ($urandom_range(0, 1) == 1) ? PKT_WORDS : int'($urandom_range(1, 12));
      send_packet(len, $urandom, 2);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    settle();
    check_stream("random");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 2; i++) send_packet(3, 32'h0000_5A00, 0);
    settle();
    total++;
    if (sat_err_count !== 2'd2) begin
      bad++;
      $display("[TB] FAIL sat_preload: got %0d want 2", sat_err_count);
    end
    sat_err_seen = 0;
    for (int i = 0; i < 3; i++) send_packet(3, 32'h0000_5B00, 1);
    settle();
    total++;
    if (sat_err_count !== 2'd3) begin
      bad++;
      $display("[TB] FAIL sat_count: got %0d want 3", sat_err_count);
    end
    total++;
    if (sat_err_seen != 3) begin
      bad++;
      $display("[TB] FAIL sat_pulses: got %0d want 3", sat_err_seen);
    end
    total++;
    if (sat_out_cycles != 0 || sat_pkt_count !== '0 || sat_data_out !== '0 || sat_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_quiet: got outcycles=%0d pkt=%0d data=%h ready=%b want 0/0/0/1",
               sat_out_cycles, sat_pkt_count, sat_data_out, sat_tready);
    end
    check_stream("sat_main");
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_short_packet();
    test_long_packet();
    test_gapped();
    test_reset_mid_drain();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depacketizer.md
Name: depacketizer

Overview:
- Receive side of the gyro HSI stream path.
- Accepts fixed-length AXI-Stream-style packets (TDATA/TVALID/TLAST, plus TREADY) of PKT_WORDS words.
- Checks framing, buffers one complete packet, then replays it as a plain word stream with a valid strobe on consecutive cycles.
- Sits between the stream interconnect and the downstream word consumer; reports packet and framing-error counts to the AXI register block.

Parameters:
- PKT_WORDS, 8: words per packet; legal range 2..64.
- DATA_W, 32: word width.
- CNT_W, 16: width of the status counters.

Ports:
- clock, in, 1: single clock for all logic, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- s_tdata, in, DATA_W: stream data.
- s_tvalid, in, 1: stream beat valid.
- s_tlast, in, 1: marks the final beat of a packet.
- s_tready, out, 1: block can accept a beat.
- data_out, out, DATA_W: replayed word.
- valid_out, out, 1: data_out is valid this cycle.
- last_out, out, 1: data_out is the final word of the packet.
- err_pulse, out, 1: one-cycle strobe on a framing error.
- pkt_count, out, CNT_W: number of good packets delivered.
- err_count, out, CNT_W: number of framing errors.

Behaviour:
- Reset values: all outputs 0 except s_tready = 1 once reset is released (it is combinational from FILL); state = FILL; wr_idx = 0; rd_idx = 0; buffer contents are don't-care.
- Asserting reset at any time, including mid-packet or mid-drain, aborts immediately. No partial output is emitted after release.
- A beat is accepted when s_tvalid & s_tready at a rising edge.
- State FILL:
  - s_tready = 1.
  - Each beat writes buf[wr_idx] and increments wr_idx.
  - s_tlast = 1 with wr_idx == PKT_WORDS-1 → DRAIN; wr_idx <= 0.
  - s_tlast = 1 with wr_idx < PKT_WORDS-1 (short packet) → packet dropped; wr_idx <= 0; stay in FILL; error event.
  - s_tlast = 0 with wr_idx == PKT_WORDS-1 (long packet) → DISCARD; wr_idx <= 0; error event.
- State DISCARD:
  - s_tready = 1; beats are consumed and not stored.
  - A beat with s_tlast = 1 → FILL.
  - No further error events are raised while in DISCARD.
- State DRAIN:
  - s_tready = 0.
  - On each edge: data_out <= buf[rd_idx], valid_out <= 1, last_out <= (rd_idx == PKT_WORDS-1), rd_idx++.
  - After the edge that outputs the final word: rd_idx <= 0; state → FILL; pkt_count increments.
- Latency and timing:
  - Let E0 be the edge accepting the final TLAST beat.
  - valid_out is high for exactly PKT_WORDS consecutive cycles, after edges E1..E_PKT_WORDS.
  - s_tready is low during those same PKT_WORDS cycles and returns high after E_PKT_WORDS, concurrent with the last output word.
- valid_out and last_out are registered and drop to 0 on the edge after the last word.
- data_out holds its last value when valid_out = 0.
- Error event: err_pulse is high for one cycle after the error edge; err_count increments.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- s_tvalid = 0 during FILL or DISCARD leaves all state unchanged; gaps are allowed anywhere within a packet.
- s_tdata and s_tlast are ignored whenever s_tready = 0.

Decomposition:
- Shared package depacketizer_pkg:
  - State encoding constants: FILL = 2'b00, DRAIN = 2'b01, DISCARD = 2'b10.
  - Index width function clog2(PKT_WORDS).
- Sub-module pkt_word_buf:
  - PKT_WORDS x DATA_W register file.
  - One write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - No reset on the storage.
- The top level holds the FSM, the indices, the output registers and the counters.

Test Plan:
- Good packet: 8 back-to-back beats 0x1000_0000..0x1000_0007, TLAST on the 8th → valid_out high for 8 cycles with the same words in order; last_out only with 0x1000_0007; pkt_count = 1; s_tready low for 8 cycles; err_count = 0.
- Short packet: 5 beats with TLAST on the 5th, then a good packet 0xA0..0xA7 → no output for the first packet; err_pulse once; err_count = 1; second packet replayed intact; pkt_count = 1.
- Long packet: 11 beats with TLAST only on the 11th, then a good packet → no output; err_pulse exactly once (after beat 8); beats 9..11 discarded; next packet delivered correctly.
- Gapped input: a good packet with s_tvalid low for 3 cycles between beats 2/3 and for 1 cycle between beats 6/7 → output identical to the back-to-back case; drain timing is measured from the TLAST edge.
- Reset mid-drain: assert reset_n = 0 after the 3rd output word → all outputs are 0 immediately, counters = 0; after release s_tready = 1 and a fresh packet is replayed correctly.
- Saturation: preload or force err_count to 0xFFFE, inject 3 short packets → err_count = 0xFFFF, err_pulse three times, no wrap.
